// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the EX-stage control and the iterative
// multiply/divide unit.
interface ex_muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            START;
   logic [2:0]      MULDIV_OP;
   logic [XLEN-1:0] OPERAND1;
   logic [XLEN-1:0] OPERAND2;
   logic [4:0]      DEST_REG;
   logic            FLUSH;
   logic            BUSY;
   logic            DONE;
   logic [XLEN-1:0] RESULT;
   logic [4:0]      OUT_DEST_REG;

   modport master (
      output START, MULDIV_OP, OPERAND1, OPERAND2, DEST_REG, FLUSH,
      input  BUSY, DONE, RESULT, OUT_DEST_REG
   );

   modport slave (
      input  START, MULDIV_OP, OPERAND1, OPERAND2, DEST_REG, FLUSH,
      output BUSY, DONE, RESULT, OUT_DEST_REG
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, sign fixed up in FIN.
module ex_muldiv_unit #(
   parameter int XLEN       = 32,
   parameter int ITER_CNT_W = 6
) (
   input logic              CLK,
   input logic              RESET,
   ex_muldiv_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   state_t                state;
   logic [2:0]            op_q;
   logic [4:0]            dest_q;
   logic                  sign1_q;
   logic                  sign2_q;
   logic                  fast_q;
   logic [ITER_CNT_W-1:0] cnt_q;
   logic [2*XLEN-1:0]     acc_q;
   logic [2*XLEN-1:0]     mcand_q;
   logic [XLEN-1:0]       opb_q;
   logic [XLEN-1:0]       quo_q;
   logic [XLEN-1:0]       rem_q;

   logic                  signed1;
   logic                  signed2;
   logic                  sgn1;
   logic                  sgn2;
   logic [XLEN-1:0]       mag1;
   logic [XLEN-1:0]       mag2;
   logic                  accept;
   logic                  div_zero;
   logic                  div_ovf;
   logic                  last_iter;
   logic [XLEN:0]         rem_shift;
   logic [XLEN:0]         rem_diff;
   logic [2*XLEN-1:0]     prod;
   logic [XLEN-1:0]       quo;
   logic [XLEN-1:0]       rem;
   logic [XLEN-1:0]       fin_result;

   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] neg_if_wide(input logic [2*XLEN-1:0] v, input logic n);
      return n ? (~v + 1'b1) : v;
   endfunction

   always_comb begin
      // MULH, MULHSU and DIV/REM treat rs1 as signed; only MULH and DIV/REM treat rs2 as signed
      signed1   = (bus.MULDIV_OP == 3'b001) || (bus.MULDIV_OP == 3'b010) ||
                  (bus.MULDIV_OP[2] && !bus.MULDIV_OP[0]);
      signed2   = (bus.MULDIV_OP == 3'b001) || (bus.MULDIV_OP[2] && !bus.MULDIV_OP[0]);
      sgn1      = signed1 && bus.OPERAND1[XLEN-1];
      sgn2      = signed2 && bus.OPERAND2[XLEN-1];
      mag1      = neg_if(bus.OPERAND1, sgn1);
      mag2      = neg_if(bus.OPERAND2, sgn2);
      accept    = bus.START && ((state == IDLE) || (state == FIN));
      div_zero  = bus.MULDIV_OP[2] && (bus.OPERAND2 == '0);
      div_ovf   = bus.MULDIV_OP[2] && !bus.MULDIV_OP[0] &&
                  (bus.OPERAND1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.OPERAND2 == '1);
      last_iter = (cnt_q == ITER_CNT_W'(XLEN-1));
      rem_shift = {rem_q, quo_q[XLEN-1]};
      rem_diff  = rem_shift - {1'b0, opb_q};

      // Fast-path results were loaded pre-signed at accept, so they bypass correction
      prod = neg_if_wide(acc_q, sign1_q ^ sign2_q);
      quo  = fast_q ? quo_q : neg_if(quo_q, sign1_q ^ sign2_q);
      rem  = fast_q ? rem_q : neg_if(rem_q, sign1_q);
      case (op_q)
         3'b000:                 fin_result = prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin_result = prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fin_result = quo;
         default:                fin_result = rem;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state            <= IDLE;
         bus.BUSY         <= 1'b0;
         bus.DONE         <= 1'b0;
         bus.RESULT       <= '0;
         bus.OUT_DEST_REG <= '0;
         op_q             <= '0;
         dest_q           <= '0;
         sign1_q          <= 1'b0;
         sign2_q          <= 1'b0;
         fast_q           <= 1'b0;
         cnt_q            <= '0;
         acc_q            <= '0;
         mcand_q          <= '0;
         opb_q            <= '0;
         quo_q            <= '0;
         rem_q            <= '0;
      end else begin
         bus.DONE <= 1'b0;
         if (bus.FLUSH) begin
            state    <= IDLE;
            bus.BUSY <= 1'b0;
         end else begin
            case (state)
               MUL: begin
                  if (opb_q[0]) acc_q <= acc_q + mcand_q;
                  mcand_q <= mcand_q << 1;
                  opb_q   <= opb_q >> 1;
                  cnt_q   <= cnt_q + 1'b1;
                  if (last_iter) begin
                     state    <= FIN;
                     bus.BUSY <= 1'b0;
                  end
               end
               DIV: begin
                  // Restoring step: keep the subtraction only when it did not borrow
                  if (!rem_diff[XLEN]) begin
                     rem_q <= rem_diff[XLEN-1:0];
                     quo_q <= {quo_q[XLEN-2:0], 1'b1};
                  end else begin
                     rem_q <= rem_shift[XLEN-1:0];
                     quo_q <= {quo_q[XLEN-2:0], 1'b0};
                  end
                  cnt_q <= cnt_q + 1'b1;
                  if (last_iter) begin
                     state    <= FIN;
                     bus.BUSY <= 1'b0;
                  end
               end
               FIN: begin
                  bus.RESULT       <= fin_result;
                  bus.OUT_DEST_REG <= dest_q;
                  bus.DONE         <= 1'b1;
                  state            <= IDLE;
               end
               default: ;
            endcase

            if (accept) begin
               op_q    <= bus.MULDIV_OP;
               dest_q  <= bus.DEST_REG;
               sign1_q <= sgn1;
               sign2_q <= sgn2;
               cnt_q   <= '0;
               fast_q  <= 1'b0;
               acc_q   <= '0;
               mcand_q <= {{XLEN{1'b0}}, mag1};
               opb_q   <= mag2;
               quo_q   <= mag1;
               rem_q   <= '0;
               if (!bus.MULDIV_OP[2]) begin
                  state    <= MUL;
                  bus.BUSY <= 1'b1;
               end else if (div_zero) begin
                  state  <= FIN;
                  fast_q <= 1'b1;
                  quo_q  <= '1;
                  rem_q  <= bus.OPERAND1;
               end else if (div_ovf) begin
                  state  <= FIN;
                  fast_q <= 1'b1;
                  quo_q  <= {1'b1, {(XLEN-1){1'b0}}};
                  rem_q  <= '0;
               end else begin
                  state    <= DIV;
                  bus.BUSY <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage. It consumes the operands, destination register and M-extension funct3 that the ID/EX pipeline register holds. It stalls the pipeline through BUSY while it iterates, then returns a 32-bit result with its destination register to the EX/MEM path, tagged by a one-cycle DONE pulse. Hazard logic drives FLUSH to abort an in-flight operation.

Parameters:
XLEN, 32, operand/result width (only 32 is supported)
ITER_CNT_W, 6, width of the iteration counter (must hold XLEN)

Ports:
CLK  input  1  clock, rising-edge
RESET  input  1  asynchronous, active-low reset
START  input  1  request a new operation; sampled at rising CLK
MULDIV_OP  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
OPERAND1  input  32  rs1 value (from ID/EX READ_DATA1 after forwarding)
OPERAND2  input  32  rs2 value
DEST_REG  input  5  destination register address
FLUSH  input  1  abort the current operation
BUSY  output  1  operation in progress; pipeline stall request
DONE  output  1  one-cycle pulse; RESULT/OUT_DEST_REG valid
RESULT  output  32  operation result
OUT_DEST_REG  output  5  destination register of the completed operation

Behaviour:
- Reset (RESET=0, async): state=IDLE; BUSY=0, DONE=0, RESULT=0, OUT_DEST_REG=0; counter and internal registers cleared. This applies mid-operation too; no DONE follows.
- States: IDLE, MUL, DIV, FIN. All outputs are registered.
- START is accepted only in IDLE or FIN. In MUL/DIV it is ignored.
- Accept: latch op, DEST_REG, operand signs and operand magnitudes. Signed operands (MULH: both; MULHSU: OPERAND1 only; DIV/REM: both) are converted to absolute value. Clear counter.
  - op[2]=0 -> MUL.
  - op[2]=1 with OPERAND2=0 -> FIN directly (fast path).
  - DIV/REM with OPERAND1=0x80000000, OPERAND2=0xFFFFFFFF -> FIN directly (fast path).
  - Any other op[2]=1 -> DIV.
- MUL: radix-2 shift-add into a 64-bit accumulator, one bit per cycle, 32 cycles. When the counter reaches 31, go to FIN.
- DIV: restoring division, one quotient bit per cycle, 32 cycles, with a 33-bit partial remainder. When the counter reaches 31, go to FIN.
- Entering FIN: apply sign correction, load RESULT and OUT_DEST_REG, DONE=1.
  - Product negated if sign1^sign2 (MULHSU: sign1 only).
  - Quotient negated if sign1^sign2; remainder takes sign1.
  - Selection: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits; DIV/DIVU = quotient; REM/REMU = remainder.
- FIN lasts one cycle. Next state is IDLE, or a new MUL/DIV/FIN if START is accepted (back-to-back).
- Latency: START sampled at edge N -> DONE high after edge N+33 for iterative ops, after edge N+1 for fast-path ops.
- BUSY=1 exactly while in MUL or DIV; 0 in IDLE and FIN.
- RESULT and OUT_DEST_REG hold their values after DONE until the next FIN.
- Divide by zero: quotient = 0xFFFFFFFF (signed and unsigned); remainder = OPERAND1.
- Signed overflow (0x80000000 / -1): quotient = 0x80000000; remainder = 0.
- FLUSH=1 at an edge: state -> IDLE, BUSY=0, DONE=0, RESULT unchanged. FLUSH beats a simultaneous START.
- Inputs are not required to stay stable after acceptance.

Test Plan:
- Reset then MUL 7 x 0xFFFFFFFD: BUSY high 32 cycles -> DONE after edge N+33, RESULT=0xFFFFFFEB, OUT_DEST_REG=5.
- MULH 0x80000000 x 0x80000000 -> RESULT=0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 100 / 0 -> DONE after edge N+1, RESULT=0xFFFFFFFF. REMU 100 / 0 -> 100. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0. BUSY never asserts in these cases.
- START held during BUSY is ignored. START in the FIN cycle (back-to-back DIVU 9/3 after MUL 2x3) -> RESULT=6, then 3 after 33 more cycles.
- FLUSH at cycle 10 of a DIV -> IDLE next edge, no DONE. RESET pulled low at cycle 15 of a MUL -> all outputs 0 immediately, no DONE.
